// File: rtl/sracc_stream.sv
// sracc_stream: streaming single-precision frame accumulator.
// Same-sign samples of a frame are summed into ACC through a four-cycle
// ALIGN/ADD/NORM pipeline. The sum is presented when the frame's last sample
// has been folded in.
//
//  state | meaning
//  IDLE  | waiting for a sample (in_ready = 1)
//  ALIGN | classify operands, align the smaller mantissa
//  ADD   | 25-bit mantissa sum
//  NORM  | renormalise, write ACC/err
//  OUT   | frame sum on out_data until out_ready
module sracc_stream #(
   parameter int MAX_EDIFF = 22
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_err
);

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, OUT} state_t;
   // What NORM does to ACC, decided once in ALIGN.
   typedef enum logic [2:0] {M_KEEP, M_REPL, M_DROP, M_OVF, M_ADD} mode_t;

   localparam logic [7:0] MAX_E = 8'(MAX_EDIFF);
   localparam logic [31:0] SAT = 32'hFFFF_FFFF;

   state_t      state, state_nx;
   mode_t       mode, mode_c;
   logic [31:0] acc, smp;
   logic        err, last_r;
   logic        sgn;
   logic [7:0]  exp_r;
   logic [23:0] mant_big, mant_sml;
   logic [24:0] sum;

   logic [7:0]  exp_a, exp_s, ediff;
   logic        a_big;
   logic [8:0]  exp_n;
   logic [22:0] frac_n;

   // Operand classification and alignment for the registered sample.
   always_comb begin
      exp_a  = acc[30:23];
      exp_s  = smp[30:23];
      a_big  = (exp_a >= exp_s);
      ediff  = a_big ? (exp_a - exp_s) : (exp_s - exp_a);
      mode_c = M_ADD;
      if (acc == SAT || smp[30:0] == 31'd0)
         mode_c = M_KEEP;
      else if (acc[30:0] == 31'd0)
         mode_c = (exp_s == 8'hFF) ? M_OVF : M_REPL;
      else if (acc[31] != smp[31])
         mode_c = M_DROP;
      else if (exp_a == 8'hFF || exp_s == 8'hFF)
         mode_c = M_OVF;
      else if (ediff > MAX_E)
         mode_c = a_big ? M_KEEP : M_REPL;
   end

   // Renormalisation of the mantissa sum; a carry bumps the exponent.
   always_comb begin
      exp_n  = {1'b0, exp_r} + {8'd0, sum[24]};
      frac_n = sum[24] ? sum[23:1] : sum[22:0];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next state and handshake outputs.
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = 32'd0;
      out_err   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = ALIGN;
         end
         ALIGN: state_nx = ADD;
         ADD:   state_nx = NORM;
         NORM:  state_nx = last_r ? OUT : IDLE;
         OUT: begin
            out_valid = 1'b1;
            out_data  = acc;
            out_err   = err;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Sample capture, datapath pipeline and accumulator update.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc      <= 32'd0;
         err      <= 1'b0;
         smp      <= 32'd0;
         last_r   <= 1'b0;
         mode     <= M_KEEP;
         sgn      <= 1'b0;
         exp_r    <= 8'd0;
         mant_big <= 24'd0;
         mant_sml <= 24'd0;
         sum      <= 25'd0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               smp    <= in_data;
               last_r <= in_last;
            end
            ALIGN: begin
               mode     <= mode_c;
               sgn      <= smp[31];
               exp_r    <= a_big ? exp_a : exp_s;
               mant_big <= a_big ? {1'b1, acc[22:0]} : {1'b1, smp[22:0]};
               mant_sml <= (a_big ? {1'b1, smp[22:0]} : {1'b1, acc[22:0]}) >> ediff;
            end
            ADD: sum <= {1'b0, mant_big} + {1'b0, mant_sml};
            NORM: begin
               case (mode)
                  M_REPL: acc <= smp;
                  M_DROP: err <= 1'b1;
                  M_OVF: begin
                     acc <= SAT;
                     err <= 1'b1;
                  end
                  M_ADD: begin
                     if (exp_n >= 9'd255) begin
                        acc <= SAT;
                        err <= 1'b1;
                     end else begin
                        acc <= {sgn, exp_n[7:0], frac_n};
                     end
                  end
                  default: ;
               endcase
            end
            OUT: if (out_ready) begin
               acc <= 32'd0;
               err <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sracc_stream.sv
// Bench for sracc_stream: directed frames plus randomized frames checked
// against an arithmetic model of the accumulation rules.
module tb_sracc_stream;

   localparam int MAX_EDIFF = 22;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = 32'd0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        out_err;

   int total = 0;
   int bad = 0;

   logic [31:0] m_acc;
   logic        m_err;

   sracc_stream #(.MAX_EDIFF(MAX_EDIFF)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Reference: float accumulation rules expressed with integer arithmetic.
   function automatic void model_add(input logic [31:0] s);
      int ea, es, ma, ms, d, e, sm;
      if (m_acc == 32'hFFFF_FFFF) return;
      if (s[30:0] == 0) return;
      ea = int'(m_acc[30:23]);
      es = int'(s[30:23]);
      if (m_acc[30:0] == 0) begin
         if (es == 255) begin m_acc = 32'hFFFF_FFFF; m_err = 1'b1; end
         else m_acc = s;
         return;
      end
      if (m_acc[31] != s[31]) begin m_err = 1'b1; return; end
      if (ea == 255 || es == 255) begin m_acc = 32'hFFFF_FFFF; m_err = 1'b1; return; end
      ma = int'(m_acc[22:0]) + (1 << 23);
      ms = int'(s[22:0]) + (1 << 23);
      d = (ea > es) ? ea - es : es - ea;
      if (d > MAX_EDIFF) begin
         if (es > ea) m_acc = s;
         return;
      end
      if (ea >= es) begin e = ea; sm = ma + (ms >> d); end
      else          begin e = es; sm = ms + (ma >> d); end
      if (sm >= (1 << 24)) begin sm = sm >> 1; e = e + 1; end
      if (e >= 255) begin m_acc = 32'hFFFF_FFFF; m_err = 1'b1; return; end
      m_acc = {s[31], 8'(e), 23'(sm)};
   endfunction

   task automatic send(input logic [31:0] d, input logic l);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; in_data = d; in_last = l;
      @(posedge clk);
      #1 in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic wait_out();
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) check("out_valid_timeout", {31'd0, out_valid}, 32'd1);
   endtask

   task automatic recv(input string tag, input logic [31:0] d, input logic e);
      wait_out();
      check({tag, "_data"}, out_data, d);
      check({tag, "_err"}, {31'd0, out_err}, {31'd0, e});
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check({tag, "_done"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      logic [31:0] s;
      logic fsgn;
      int nsmp, r;

      repeat (3) @(posedge clk);
      #1 check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_err", {31'd0, out_err}, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      // Cycle-exact two-sample frame.
      @(negedge clk);
      check("cyc0_in_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; in_data = 32'h3F80_0000; in_last = 1'b0;
      @(posedge clk); #1 in_valid = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         check($sformatf("cyc%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
      end
      @(negedge clk);
      check("cyc4_in_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; in_data = 32'h3F80_0000; in_last = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0; in_last = 1'b0;
      for (int i = 5; i <= 7; i++) begin
         @(negedge clk);
         check($sformatf("cyc%0d_out_valid", i), {31'd0, out_valid}, 32'd0);
      end
      @(negedge clk);
      check("cyc8_out_valid", {31'd0, out_valid}, 32'd1);
      recv("one_plus_one", 32'h4000_0000, 1'b0);

      send(32'h3F80_0000, 0); send(32'h3F80_0000, 0); send(32'h3F80_0000, 1);
      recv("three_ones", 32'h4040_0000, 1'b0);
      send(32'h3FC0_0000, 0); send(32'h3FC0_0000, 1);
      recv("carry_norm", 32'h4040_0000, 1'b0);
      send(32'h3F80_0000, 0); send(32'h3380_0000, 1);
      recv("ediff24", 32'h3F80_0000, 1'b0);
      send(32'h0000_0000, 0); send(32'hBF80_0000, 1);
      recv("zero_replace", 32'hBF80_0000, 1'b0);
      send(32'h3F80_0000, 0); send(32'hBF80_0000, 1);
      recv("sign_mismatch", 32'h3F80_0000, 1'b1);
      send(32'h7F7F_FFFF, 0); send(32'h7F7F_FFFF, 1);
      recv("overflow", 32'hFFFF_FFFF, 1'b1);
      send(32'h0000_0000, 0); send(32'h8000_0000, 1);
      recv("all_zero", 32'h0000_0000, 1'b0);

      // Backpressure: output held while out_ready is low.
      send(32'h3F80_0000, 0); send(32'h4000_0000, 1);
      wait_out();
      in_valid = 1'b1; in_data = 32'h1234_5678;
      for (int i = 0; i < 5; i++) begin
         check("hold_out_valid", {31'd0, out_valid}, 32'd1);
         check("hold_out_data", out_data, 32'h4040_0000);
         check("hold_in_ready", {31'd0, in_ready}, 32'd0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      recv("hold_release", 32'h4040_0000, 1'b0);
      send(32'h3F80_0000, 1);
      recv("after_hold", 32'h3F80_0000, 1'b0);

      // Reset during ADD of the second sample.
      send(32'h3F80_0000, 0); send(32'h3F80_0000, 1);
      @(posedge clk);
      @(negedge clk) rst_n = 1'b0;
      @(posedge clk);
      #1 check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_out_data", out_data, 32'd0);
      check("midrst_out_err", {31'd0, out_err}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      send(32'h4000_0000, 1);
      recv("post_reset", 32'h4000_0000, 1'b0);

      // Randomized frames against the model.
      for (int f = 0; f < 40; f++) begin
         m_acc = 32'd0; m_err = 1'b0;
         nsmp = $urandom_range(1, 5);
         fsgn = 1'($urandom_range(0, 1));
         for (int k = 0; k < nsmp; k++) begin
            r = $urandom_range(0, 99);
            if (r < 10) s = {1'($urandom_range(0, 1)), 31'd0};
            else begin
               s[31] = (r < 18) ? ~fsgn : fsgn;
               s[30:23] = (r > 95) ? 8'($urandom_range(250, 254)) : 8'($urandom_range(115, 140));
               s[22:0] = 23'($urandom);
            end
            model_add(s);
            send(s, k == nsmp - 1);
         end
         recv($sformatf("rand%0d", f), m_acc, m_err);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sracc_stream.md
SRACC_STREAM -- requirements
Module: sracc_stream

Interface
REQ-001 SHALL have parameter MAX_EDIFF, default 22: exponent difference above which the smaller operand is discarded.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  in_data/in_last valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a sample.
REQ-006 SHALL have port in_data  input  32  single-precision sample.
REQ-007 SHALL have port in_last  input  1  sample closes the current sum frame.
REQ-008 SHALL have port out_valid  output  1  frame sum available.
REQ-009 SHALL have port out_ready  input  1  downstream accepts sum.
REQ-010 SHALL have port out_data  output  32  single-precision frame sum.
REQ-011 SHALL have port out_err  output  1  sign mismatch or overflow occurred in the frame.

Function
REQ-012 SHALL accumulate a frame of same-sign samples, terminated by in_last, into one 32-bit register ACC, and present the sum on out_data.
REQ-013 SHALL implement FSM states IDLE, ALIGN, ADD, NORM, OUT; in_ready = 1 only in IDLE; out_valid = 1 only in OUT.
REQ-014 SHALL, on in_valid && in_ready in IDLE, register in_data/in_last and move to ALIGN; then ADD, then NORM, each exactly one cycle.
REQ-015 SHALL write ACC at the end of NORM, then go to OUT if the registered in_last = 1, else to IDLE; max throughput is one sample per 4 cycles.
REQ-016 SHALL, in ALIGN, compute ediff = |exp(ACC) - exp(sample)|; the operand with the larger exponent keeps its exponent; the other 24-bit mantissa (hidden one restored) is right-shifted by ediff, truncated.
REQ-017 SHALL treat 32'h00000000 and 32'h80000000 as zero: a zero sample leaves ACC unchanged; a zero ACC is replaced by the sample verbatim, including its sign.
REQ-018 SHALL, when ediff > MAX_EDIFF, leave the larger-exponent operand as the result unchanged.
REQ-019 SHALL, in ADD, form a 25-bit mantissa sum; in NORM, if bit 24 is set, shift right 1 (truncate) and increment exponent; no rounding.
REQ-020 SHALL, if the sample sign differs from a nonzero ACC sign, drop the sample (ACC unchanged) and set sticky err.
REQ-021 SHALL, if the result exponent reaches 8'hFF or either operand has exponent 8'hFF, set ACC to 32'hFFFFFFFF and set err; once ACC = 32'hFFFFFFFF, later samples in the frame are consumed but ignored.
REQ-022 SHALL, in OUT, drive out_data = ACC and out_err = err, held stable while out_ready = 0.
REQ-023 SHALL, on out_valid && out_ready, clear ACC to 0 and err to 0 and return to IDLE in the next cycle.
REQ-024 SHALL keep in_ready = 0 during ALIGN, ADD, NORM and OUT, regardless of in_valid.
REQ-025 SHALL count a frame containing only zero samples as valid, with output 32'h00000000 and err = 0.

Reset
REQ-026 SHALL, on the first edge with rst_n = 0, set state = IDLE, ACC = 0, err = 0, out_valid = 0, out_data = 0, out_err = 0; in_ready = 1 from the next cycle after rst_n = 1.
REQ-027 SHALL, on reset mid-frame (any state), discard the partial frame and any registered sample; no output is produced for it.

Verification
REQ-028 SHALL test 3F800000 accepted at cycle 0, then 3F800000 with last at cycle 4 -> out_valid at cycle 8, out_data 40000000, out_err 0.
REQ-029 SHALL test 3F800000, 3F800000, 3F800000(last) -> 40400000; also 3FC00000 + 3FC00000(last) -> 40400000.
REQ-030 SHALL test 3F800000 + 33800000(last), ediff = 24 -> 3F800000, err 0; and 00000000 + BF800000(last) -> BF800000.
REQ-031 SHALL test 3F800000 + BF800000(last) -> 3F800000, out_err 1; and 7F7FFFFF + 7F7FFFFF(last) -> FFFFFFFF, out_err 1.
REQ-032 SHALL test out_ready held 0 for 5 cycles -> out_data and out_valid stable and in_ready 0 throughout; on release, ACC = 0 and the next frame is independent.
REQ-033 SHALL test rst_n = 0 during ADD of the second sample -> all outputs 0; a following frame of 40000000(last) -> 40000000.
